// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: operand FIFO, single-issue sequencer and result holder for
// an external n-bit divider. Divide-by-zero is answered locally and a watchdog
// turns a hung divider into an error result.
module div_issue_ctrl #(
  parameter int N       = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_dividend,
  input  logic [N-1:0] in_divisor,
  output logic         div_start,
  output logic [N-1:0] div_dividend,
  output logic [N-1:0] div_divisor,
  input  logic         div_done,
  input  logic [N-1:0] div_quotient,
  input  logic [N-1:0] div_remainder,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_quotient,
  output logic [N-1:0] out_remainder,
  output logic         out_dz,
  output logic         out_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;

  state_t r_state;
  state_t w_state_next;

  // Operand storage; read only through a registered pop so it maps to RAM.
  logic [N-1:0] r_mem_dvd [DEPTH];
  logic [N-1:0] r_mem_dvs [DEPTH];
  // Per-entry "divisor is zero" flags kept in flops so IDLE can branch on the
  // head entry in the same cycle it is popped.
  logic [DEPTH-1:0] r_zero;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [WW-1:0] r_wd;

  logic [N-1:0] r_op_dvd;
  logic [N-1:0] r_op_dvs;
  logic [N-1:0] r_res_q;
  logic [N-1:0] r_res_r;
  logic         r_res_dz;
  logic         r_res_err;

  logic w_push;
  logic w_pop;
  logic w_head_zero;
  logic w_done_hit;
  logic w_timeout;

  // Full flag does not look at a same-cycle pop, keeping in_ready a pure flop decode.
  assign in_ready    = (r_count != CW'(DEPTH));
  assign w_push      = in_valid && in_ready;
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
  assign w_head_zero = r_zero[r_rd_ptr];
  assign w_done_hit  = (r_state == S_WAIT) && div_done;
  assign w_timeout   = (r_state == S_WAIT) && !div_done && (r_wd == WW'(TIMEOUT - 1));

  // Operand RAM write port.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_dvd[r_wr_ptr] <= in_dividend;
      r_mem_dvs[r_wr_ptr] <= in_divisor;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_zero
      // Record whether the entry being written carries a zero divisor.
      always_ff @(posedge clk) begin
        if (!reset) begin
          r_zero[gi] <= 1'b0;
        end else if (w_push && (r_wr_ptr == AW'(gi))) begin
          r_zero[gi] <= (in_divisor == '0);
        end
      end
    end
  endgenerate

  // FIFO pointers and occupancy; push and pop together leave the count alone.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic; a zero divisor skips the divider entirely.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_pop) w_state_next = w_head_zero ? S_OUT : S_ISSUE;
      S_ISSUE: w_state_next = S_WAIT;
      S_WAIT:  if (w_done_hit || w_timeout) w_state_next = S_OUT;
      S_OUT:   if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state.
  always_comb begin
    div_start = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_ISSUE: div_start = 1'b1;
      S_OUT:   out_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand registers: loaded on pop, held until the next pop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_op_dvd <= '0;
      r_op_dvs <= '0;
    end else if (w_pop) begin
      r_op_dvd <= r_mem_dvd[r_rd_ptr];
      r_op_dvs <= r_mem_dvs[r_rd_ptr];
    end
  end

  // Result registers: written by the zero trap, divider completion or timeout.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_res_q   <= '0;
      r_res_r   <= '0;
      r_res_dz  <= 1'b0;
      r_res_err <= 1'b0;
    end else if (w_pop && w_head_zero) begin
      r_res_q   <= '1;
      r_res_r   <= r_mem_dvd[r_rd_ptr];
      r_res_dz  <= 1'b1;
      r_res_err <= 1'b0;
    end else if (w_done_hit) begin
      r_res_q   <= div_quotient;
      r_res_r   <= div_remainder;
      r_res_dz  <= 1'b0;
      r_res_err <= 1'b0;
    end else if (w_timeout) begin
      r_res_q   <= '0;
      r_res_r   <= '0;
      r_res_dz  <= 1'b0;
      r_res_err <= 1'b1;
    end
  end

  // Watchdog: cleared while issuing, counts every cycle spent waiting.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wd <= '0;
    end else if (r_state == S_ISSUE) begin
      r_wd <= '0;
    end else if (r_state == S_WAIT) begin
      r_wd <= r_wd + 1'b1;
    end
  end

  assign div_dividend  = r_op_dvd;
  assign div_divisor   = r_op_dvs;
  assign out_quotient  = r_res_q;
  assign out_remainder = r_res_r;
  assign out_dz        = r_res_dz;
  assign out_err       = r_res_err;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural 10-cycle divider and a
// result scoreboard checked on every output handshake.
module tb_div_issue_ctrl;

  localparam int N       = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_dividend = '0;
  logic [N-1:0] in_divisor = '0;
  logic         div_start;
  logic [N-1:0] div_dividend;
  logic [N-1:0] div_divisor;
  logic         div_done;
  logic [N-1:0] div_quotient;
  logic [N-1:0] div_remainder;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out_quotient;
  logic [N-1:0] out_remainder;
  logic         out_dz;
  logic         out_err;

  typedef struct packed {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    logic         err;
  } res_t;

  res_t sb[$];
  res_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   n_start = 0;
  int   m_ndone = 0;

  always #5 clk = ~clk;

  div_issue_ctrl #(.N(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder),
    .out_dz(out_dz), .out_err(out_err)
  );

  // Behavioural divider: done 10 cycles after start; it ignores our reset,
  // as a real external block would. m_hang suppresses done.
  logic         m_busy = 1'b0;
  int           m_cnt = 0;
  logic         m_done = 1'b0;
  logic         m_hang = 1'b0;
  logic         inj_done = 1'b0;
  logic [N-1:0] m_a = '0, m_b = '0, m_q = '0, m_r = '0;

  // Divider model.
  always @(posedge clk) begin
    m_done <= 1'b0;
    if (m_busy) begin
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        if (!m_hang) begin
          m_done  <= 1'b1;
          m_q     <= m_a / m_b;
          m_r     <= m_a % m_b;
          m_ndone <= m_ndone + 1;
        end
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (div_start) begin
      m_busy <= 1'b1;
      m_cnt  <= 10;
      m_a    <= div_dividend;
      m_b    <= div_divisor;
    end
  end

  assign div_done      = m_done | inj_done;
  assign div_quotient  = inj_done ? 8'hAA : m_q;
  assign div_remainder = inj_done ? 8'h55 : m_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Count start pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (div_start) n_start++;
  end

  // Scoreboard: compare each result as it is handed over.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      chk("sb_has_expected", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        $display("result q=%02h r=%02h dz=%0d err=%0d (exp q=%02h r=%02h dz=%0d err=%0d)",
                 out_quotient, out_remainder, out_dz, out_err, mon_e.q, mon_e.r, mon_e.dz, mon_e.err);
        chk("res_quotient",  out_quotient,  mon_e.q);
        chk("res_remainder", out_remainder, mon_e.r);
        chk("res_dz",        out_dz,        mon_e.dz);
        chk("res_err",       out_err,       mon_e.err);
      end
    end
  end

  function automatic res_t exp_of(input logic [N-1:0] a, input logic [N-1:0] b, input logic hang);
    res_t e;
    if (hang) begin
      e.q = '0; e.r = '0; e.dz = 1'b0; e.err = 1'b1;
    end else if (b == '0) begin
      e.q = '1; e.r = a; e.dz = 1'b1; e.err = 1'b0;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0; e.err = 1'b0;
    end
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [N-1:0] a, input logic [N-1:0] b, input logic hang, output logic acc);
    in_valid = 1'b1; in_dividend = a; in_divisor = b;
    acc = in_ready;
    if (acc) sb.push_back(exp_of(a, b, hang));
    $display("push %02h/%02h accepted=%0d", a, b, acc);
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int max, output int n);
    n = 0;
    while (!out_valid && n < max) begin
      tick(1);
      n++;
    end
    chk(tag, out_valid, 1);
  endtask

  task automatic wait_drain(input string tag, input int max);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max) begin
      tick(1);
      n++;
    end
    chk(tag, sb.size(), 0);
  endtask

  initial begin
    logic acc;
    int   n, s0, nacc, d0;
    logic seen;

    // Reset state.
    tick(2);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_div_start", div_start, 0);
    chk("rst_out_q", out_quotient, 0);
    chk("rst_out_dz_err", {out_dz, out_err}, 0);
    chk("rst_div_operands", {div_dividend, div_divisor}, 0);
    reset = 1'b1;
    out_ready = 1'b1;

    // Normal division 0x17/0x03.
    s0 = n_start;
    push(8'h17, 8'h03, 1'b0, acc);
    tick(1);
    chk("issue_start_high", div_start, 1);
    chk("issue_operands", {div_dividend, div_divisor}, 16'h1703);
    tick(1);
    chk("start_one_cycle", div_start, 0);
    wait_valid("normal_valid", 40, n);
    tick(1);
    chk("normal_one_start", n_start - s0, 1);

    // Divide by zero: trapped locally.
    s0 = n_start;
    push(8'h17, 8'h00, 1'b0, acc);
    wait_valid("dz_valid", 2, n);
    tick(1);
    chk("dz_no_start", n_start - s0, 0);

    // Capacity: one op held in OUT plus DEPTH in the FIFO.
    out_ready = 1'b0;
    nacc = 0;
    push(8'd23, 8'd3, 1'b0, acc);   nacc += int'(acc);
    push(8'd40, 8'd7, 1'b0, acc);   nacc += int'(acc);
    push(8'd9, 8'd9, 1'b0, acc);    nacc += int'(acc);
    push(8'd0, 8'd5, 1'b0, acc);    nacc += int'(acc);
    push(8'd255, 8'd16, 1'b0, acc); nacc += int'(acc);
    push(8'd1, 8'd1, 1'b0, acc);    nacc += int'(acc);
    chk("cap_accepted", nacc, DEPTH + 1);
    chk("cap_in_ready_low", in_ready, 0);
    wait_valid("cap_first_valid", 40, n);
    chk("cap_full_in_out", in_ready, 0);

    // Push offered while full, across the IDLE pop: must be rejected.
    in_valid = 1'b1; in_dividend = 8'h55; in_divisor = 8'h05;
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    chk("full_at_idle_pop", in_ready, 0);
    tick(1);
    chk("pop_frees_slot", in_ready, 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain("cap_drain", 300);

    // Hung divider: timeout error, then a late done is ignored.
    tick(2);
    m_hang = 1'b1;
    push(8'h30, 8'h04, 1'b1, acc);
    tick(1);
    chk("hang_issue", div_start, 1);
    wait_valid("hang_valid", TIMEOUT + 5, n);
    chk("hang_latency", n, TIMEOUT + 1);
    tick(1);
    inj_done = 1'b1;
    tick(1);
    inj_done = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      tick(1);
      seen |= out_valid;
    end
    chk("late_done_ignored", seen, 0);
    m_hang = 1'b0;
    push(8'h64, 8'h0A, 1'b0, acc);
    wait_drain("after_hang_drain", 40);

    // Reset during WAIT with three ops queued.
    tick(2);
    push(8'd80, 8'd9, 1'b0, acc);
    push(8'd77, 8'd7, 1'b0, acc);
    push(8'd200, 8'd3, 1'b0, acc);
    push(8'd15, 8'd4, 1'b0, acc);
    d0 = m_ndone;
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    sb.delete();
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_in_ready", in_ready, 1);
    seen = 1'b0;
    repeat (20) begin
      tick(1);
      seen |= out_valid | div_start;
    end
    chk("rst2_quiet", seen, 0);
    chk("rst2_done_arrived", (m_ndone > d0), 1);

    // Normal operation after reset.
    push(8'hC8, 8'h07, 1'b0, acc);
    wait_drain("final_drain", 40);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
Upstream feeder and result collector for the team's n-bit non-restoring divider (nDiv). It accepts dividend/divisor pairs on a valid/ready stream and buffers them in a small FIFO. It issues one operation at a time to the divider with a single-cycle start pulse, waits for done, then captures quotient/remainder into an output register with valid/ready handshake. Divide-by-zero is trapped locally without using the divider, and a watchdog flags a hung divider.

Parameters:
N, 8, operand/result width (matches divider n)
DEPTH, 4, operand FIFO entries (power of 2, >=2)
TIMEOUT, 64, max cycles in WAIT before error (must exceed divider latency)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous active-low reset (0 = reset)
in_valid  input  1  operand pair valid
in_ready  output  1  FIFO can accept (= !full)
in_dividend  input  N  dividend
in_divisor  input  N  divisor
div_start  output  1  start pulse to divider
div_dividend  output  N  dividend to divider
div_divisor  output  N  divisor to divider
div_done  input  1  divider completion
div_quotient  input  N  divider quotient
div_remainder  input  N  divider remainder
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_quotient  output  N  result quotient
out_remainder  output  N  result remainder
out_dz  output  1  result was divide-by-zero
out_err  output  1  result is a divider timeout

Behaviour:
- Reset (reset=0 at clk edge): FIFO empty (count=0, pointers=0), state=IDLE, watchdog=0. All outputs 0 except in_ready=1. Reset mid-operation discards in-flight op and FIFO contents. A divider result arriving afterwards is ignored.
- FIFO: push when in_valid&&in_ready; in_ready = (count!=DEPTH), independent of same-cycle pop. Pop only in IDLE. Simultaneous push+pop keeps count unchanged. Pointers wrap mod DEPTH. Order preserved.
- FSM states: IDLE, ISSUE, WAIT, OUT.
- IDLE: if FIFO non-empty, pop head into operand regs.
  - divisor==0 -> OUT with quotient={N{1}}, remainder=dividend, dz=1, err=0. No div_start.
  - else -> ISSUE.
- ISSUE: div_start=1 for exactly this one cycle; watchdog cleared; -> WAIT.
- div_dividend/div_divisor driven from operand regs. They are stable from ISSUE until leaving WAIT, and hold their last value otherwise.
- WAIT: watchdog increments each cycle.
  - div_done=1 -> capture div_quotient/div_remainder into output regs, dz=0, err=0, -> OUT.
  - else watchdog==TIMEOUT-1 -> quotient=0, remainder=0, err=1, -> OUT.
  - div_done has priority over timeout in the same cycle.
  - div_done outside WAIT is ignored.
- OUT: out_valid=1 and output regs held stable. On out_ready=1 -> IDLE; out_valid drops next cycle, outputs keep last value.
- Latency: a pair pushed at edge t is popped at t+1 if the FSM is idle. div_start is high in cycle t+1..t+2 (ISSUE). out_valid rises the cycle after div_done is sampled.
- Minimum gap between successive div_start pulses is 3 cycles (WAIT>=1, OUT>=1, IDLE 1).
- Capacity with out_ready held low: 1 op held in OUT + DEPTH in FIFO.
- Arithmetic: no width growth. All values N bits unsigned, passed through unmodified.

Test Plan:
- Divider model (done after 10 cycles) with dividend=8'h17, divisor=8'h03 -> exactly one div_start pulse; out_quotient=8'h07, out_remainder=8'h02, out_dz=0, out_err=0.
- Dividend=8'h17, divisor=0 -> no div_start; out_quotient=8'hFF, out_remainder=8'h17, out_dz=1, out_valid within 2 cycles of push.
- out_ready=0, push 6 pairs back-to-back -> exactly 5 accepted, then in_ready=0. Release out_ready -> 5 results in push order (e.g. 23/3, 40/7, 9/9, 0/5, 255/16 -> q 7,5,1,0,15; r 2,5,0,0,15).
- Divider model never asserts done -> out_valid with out_err=1, q=r=0 exactly TIMEOUT cycles after ISSUE. Late div_done then ignored; next op completes normally.
- Reset low for 1 cycle while in WAIT with 3 ops queued -> out_valid=0, in_ready=1, next-cycle FIFO empty; later done pulse produces no output.
- Simultaneous push while FIFO full and IDLE popping -> push rejected (in_ready=0); count goes DEPTH -> DEPTH-1.
